// File: rtl/codec_pkg.sv
// Widths and FSM encoding shared by the encoder divider and the decoder multiplier.
// The width check keeps the quotient/remainder reconstruction free of truncation.
package codec_pkg;

    localparam int QUO_W = 9;
    localparam int M_W   = 12;
    localparam int REM_W = 9;
    localparam int Q_W   = 21;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    function automatic bit widths_ok(input int q_w, input int quo_w, input int m_w);
        return q_w >= quo_w + m_w;
    endfunction

    localparam bit WIDTHS_OK = widths_ok(Q_W, QUO_W, M_W);

endpackage

// File: rtl/seq_multiplier.sv
// Shift-add multiply-accumulate: Q = Quo * M + Rem, one quotient bit per clock.
// Also flags triples whose remainder is not below the divisor.
module seq_multiplier #(
    parameter int QUO_W = codec_pkg::QUO_W,
    parameter int M_W   = codec_pkg::M_W,
    parameter int REM_W = codec_pkg::REM_W,
    parameter int Q_W   = codec_pkg::Q_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [QUO_W-1:0] Quo,
    input  logic [M_W-1:0]   M,
    input  logic [REM_W-1:0] Rem,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Q_W-1:0]   Q,
    output logic             rem_ovf
);
    import codec_pkg::*;

    localparam int CNT_W = $clog2(QUO_W + 1);

    if (!widths_ok(Q_W, QUO_W, M_W)) begin : g_width_check
        $error("seq_multiplier: Q_W must be at least QUO_W + M_W");
    end

    state_t             state, state_n;
    logic [Q_W-1:0]     acc, mcand, acc_sum, q_r;
    logic [QUO_W-1:0]   qsh;
    logic [CNT_W-1:0]   cnt;
    logic               rem_ovf_r, out_valid_r, last_step;

    assign acc_sum   = acc + (qsh[0] ? mcand : '0);
    assign last_step = (cnt == CNT_W'(QUO_W - 1));

    assign in_ready  = (state == IDLE);
    assign out_valid = out_valid_r;
    assign Q         = q_r;
    assign rem_ovf   = rem_ovf_r;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (in_valid)  state_n = CALC;
            CALC:    if (last_step) state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc         <= '0;
            mcand       <= '0;
            qsh         <= '0;
            cnt         <= '0;
            rem_ovf_r   <= 1'b0;
            q_r         <= '0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc       <= Q_W'(Rem);
                        mcand     <= Q_W'(M);
                        qsh       <= Quo;
                        cnt       <= '0;
                        // Unsigned compare at a common width; M = 0 always flags.
                        rem_ovf_r <= (Q_W'(Rem) >= Q_W'(M));
                    end
                end
                CALC: begin
                    acc   <= acc_sum;
                    mcand <= mcand << 1;
                    qsh   <= qsh >> 1;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_step) begin
                        q_r         <= acc_sum;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid_r <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed table, random table against an
// arithmetic model, and hand-written hold / reset-abort / back-to-back sequences.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, rem_ovf;
    logic [8:0]  Quo;
    logic [11:0] M;
    logic [8:0]  Rem;
    logic [20:0] Q;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [8:0]  quo;
        logic [11:0] m;
        logic [8:0]  rem;
        logic [20:0] exp_q;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q_fifo[$];

    seq_multiplier dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .Quo(Quo), .M(M), .Rem(Rem),
        .out_valid(out_valid), .out_ready(out_ready),
        .Q(Q), .rem_ovf(rem_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic on the triple.
    function automatic vec_t model(input logic [8:0] a, input logic [11:0] b, input logic [8:0] c);
        vec_t v;
        longint r;
        r = longint'(a) * longint'(b) + longint'(c);
        v.quo = a; v.m = b; v.rem = c;
        v.exp_q = r[20:0];
        v.exp_ovf = (int'(c) >= int'(b));
        return v;
    endfunction

    function automatic vec_t mkvec(input logic [8:0] a, input logic [11:0] b, input logic [8:0] c,
                                   input logic [20:0] q, input logic o);
        vec_t v;
        v.quo = a; v.m = b; v.rem = c; v.exp_q = q; v.exp_ovf = o;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [8:0] a, input logic [11:0] b, input logic [8:0] c);
        int t = 0;
        while (!in_ready && t < 40) begin
            tick();
            t++;
        end
        chk("ready_before_send", in_ready, 1);
        in_valid = 1'b1; Quo = a; M = b; Rem = c;
        tick();
        in_valid = 1'b0;
        Quo = '0; M = '0; Rem = '0;
    endtask

    task automatic wait_result(output int lat);
        bit ready_seen = 0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
            if (in_ready) ready_seen = 1;
        end
        chk("in_ready_low_while_busy", ready_seen, 0);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_after_release", out_valid, 0);
        chk("in_ready_after_release", in_ready, 1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        send(v.quo, v.m, v.rem);
        wait_result(lat);
        chk({tag, "_latency"}, lat, 9);
        chk({tag, "_Q"}, Q, v.exp_q);
        chk({tag, "_rem_ovf"}, rem_ovf, v.exp_ovf);
        release_result();
    endtask

    initial begin
        int lat;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        Quo = '0; M = '0; Rem = '0;
        repeat (2) tick();
        rst = 1'b0;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_Q", Q, 0);
        chk("reset_rem_ovf", rem_ovf, 0);

        // Directed vectors with hand-derived results.
        vecs.push_back(mkvec(9'd100, 12'd37, 9'd5, 21'd3705, 1'b0));
        vecs.push_back(mkvec(9'h1FF, 12'hFFF, 9'h1FF, 21'h1FF000, 1'b0));
        vecs.push_back(mkvec(9'd7, 12'd0, 9'd3, 21'd3, 1'b1));
        vecs.push_back(mkvec(9'd0, 12'd5, 9'd5, 21'd5, 1'b1));
        vecs.push_back(mkvec(9'd1, 12'd1, 9'd0, 21'd1, 1'b0));
        for (int i = 0; i < 16; i++) begin
            logic [8:0]  a = 9'($urandom_range(0, 511));
            logic [11:0] b = (i % 3 == 0) ? 12'($urandom_range(0, 600)) : 12'($urandom_range(0, 4095));
            logic [8:0]  c = 9'($urandom_range(0, 511));
            vecs.push_back(model(a, b, c));
        end
        for (int i = 0; i < vecs.size(); i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Round trip, then a stalled consumer with noisy inputs.
        send(9'd246, 12'd500, 9'd456);
        wait_result(lat);
        chk("hold_latency", lat, 9);
        chk("hold_Q", Q, 123456);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            Quo = 9'($urandom); M = 12'($urandom); Rem = 9'($urandom);
            tick();
            chk("hold_Q_stable", Q, 123456);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_no_accept", in_ready, 0);
        end
        in_valid = 1'b0;
        release_result();

        // Reset during the 4th CALC step aborts the operation.
        send(9'd300, 12'd999, 9'd17);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_Q", Q, 0);
        chk("abort_in_ready", in_ready, 1);
        begin
            bit pulse = 0;
            for (int i = 0; i < 12; i++) begin
                tick();
                if (out_valid) pulse = 1;
            end
            chk("abort_no_pulse", pulse, 0);
        end
        run_vec(mkvec(9'd1, 12'd1, 9'd0, 21'd1, 1'b0), "post_abort");

        // Back-to-back with out_ready tied high: one result every 11 cycles.
        begin
            int cyc = 0, last = -1, nres = 0;
            out_ready = 1'b1;
            in_valid = 1'b1;
            while (nres < 4 && cyc < 100) begin
                if (out_valid) begin
                    vec_t e;
                    if (exp_q_fifo.size() == 0) begin
                        chk("b2b_unexpected_result", 1, 0);
                    end else begin
                        e = exp_q_fifo.pop_front();
                        chk("b2b_Q", Q, e.exp_q);
                        chk("b2b_rem_ovf", rem_ovf, e.exp_ovf);
                    end
                    if (last >= 0) chk("b2b_spacing", cyc - last, 11);
                    last = cyc;
                    nres++;
                end
                if (in_ready) begin
                    logic [8:0]  a = 9'($urandom_range(0, 511));
                    logic [11:0] b = 12'($urandom_range(0, 4095));
                    logic [8:0]  c = 9'($urandom_range(0, 511));
                    Quo = a; M = b; Rem = c;
                    exp_q_fifo.push_back(model(a, b, c));
                end
                tick();
                cyc++;
            end
            chk("b2b_result_count", nres, 4);
            in_valid = 1'b0;
            repeat (12) tick();
            out_ready = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Sequential shift-add multiplier-accumulator that reconstructs a 21-bit dividend from a (quotient, divisor, remainder) triple: Q = Quo × M + Rem. It is the decode-side inverse of the encoder's combinational restoring divider, which maps a 21-bit Q and 12-bit M to a 9-bit quotient and 9-bit remainder. It sits in the decoder path and is fed one triple at a time through a valid/ready handshake. It takes one quotient bit per clock.

## Interface
- QUO_W, default 9: quotient width; also the number of CALC cycles.
- M_W, default 12: divisor width.
- REM_W, default 9: remainder width.
- Q_W, default 21: result width; must be at least QUO_W + M_W.
- clk  input  1  sole clock; rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  Quo/M/Rem valid.
- in_ready  output  1  block can accept a triple; high only in IDLE.
- Quo  input  QUO_W  quotient.
- M  input  M_W  divisor.
- Rem  input  REM_W  remainder.
- out_valid  output  1  Q and rem_ovf valid.
- out_ready  input  1  consumer accepts the result.
- Q  output  Q_W  reconstructed dividend.
- rem_ovf  output  1  flags an inconsistent triple: Rem ≥ M, including the case M = 0.

## Operation
- States: IDLE, CALC, DONE. One clock; reset is synchronous and active-high.
- **IDLE**
  - in_ready = 1.
  - On in_valid at an edge, load:
    - acc ← zero-extended Rem (Q_W bits).
    - mcand ← zero-extended M (Q_W bits).
    - qsh ← Quo.
    - cnt ← 0.
    - rem_ovf_r ← (Rem ≥ M), as an unsigned compare.
  - Then go to CALC.
- **CALC**, one step per edge:
  - If qsh[0] = 1, acc ← acc + mcand.
  - mcand ← mcand << 1.
  - qsh ← qsh >> 1.
  - cnt ← cnt + 1.
  - The step with cnt = QUO_W−1 registers Q ← the final acc and out_valid ← 1, and moves to DONE.
  - The step count is fixed and independent of operand values; there is no early exit.
- **Arithmetic**
  - Q_W-bit adds cannot overflow when Q_W ≥ QUO_W + M_W. With the defaults, the maximum result is 511 × 4095 + 511 = 2,093,056 < 2^21.
  - No truncation is permitted.
- **DONE**
  - Q and rem_ovf are held stable while out_ready = 0.
  - At an edge with out_ready = 1: out_valid ← 0, go to IDLE.
- in_valid is ignored outside IDLE, and inputs are not sampled there.
- M = 0 is legal: Q = Rem and rem_ovf = 1.
- Reset values:
  - State = IDLE.
  - in_ready = 1, from the cycle after the reset edge.
  - out_valid = 0, Q = 0, rem_ovf = 0.
  - acc, mcand, qsh and cnt are all 0.
- Reset asserted in CALC or DONE aborts the operation: the result is discarded and no out_valid pulse is produced.

## Timing
- Accept edge E0: in_valid & in_ready sampled high.
- CALC steps occur at edges E1..E9 (E1..E_QUO_W in general). out_valid is registered high at E9 and visible in the cycle after E9.
- Latency: out_valid rises 9 cycles after the accept edge.
- Release edge Er: the first edge in DONE with out_ready = 1. in_ready is high in the cycle after Er.
- Maximum throughput: one result per 11 cycles, achieved when out_ready is held high and in_valid is waiting.
- out_valid never falls without out_ready. Q never changes while out_valid = 1.
- in_ready is decoded directly from the state register (IDLE), with no combinational path from in_valid.

## Structure
- Shared package `codec_pkg` holds:
  - The width constants QUO_W = 9, M_W = 12, REM_W = 9, Q_W = 21, shared with the encoder divider.
  - The state enum {IDLE, CALC, DONE}.
  - A width-consistency check (Q_W ≥ QUO_W + M_W) asserted at elaboration.
- Implementation is a single module. No sub-module is needed; the step adder is one Q_W-bit add inside the datapath.

## Test plan
- Quo = 100, M = 37, Rem = 5, accepted at E0 → Q = 3705 (0xE79), rem_ovf = 0, out_valid first high after E9, in_ready low E1..Er.
- Quo = 0x1FF, M = 0xFFF, Rem = 0x1FF → Q = 0x1FF000 (2,093,056), rem_ovf = 0; no overflow at maximum operands.
- Quo = 7, M = 0, Rem = 3 → Q = 3, rem_ovf = 1.
- Round trip with encoder values: Quo = 246, M = 500, Rem = 456 → Q = 123456. Then hold out_ready = 0 for 5 cycles with in_valid = 1 and changing inputs → Q stays 123456, out_valid stays 1, no new accept occurs, and in_ready rises the cycle after out_ready goes high.
- Assert rst for one edge at the 4th CALC step → out_valid stays 0, Q = 0, in_ready = 1 the next cycle. A following triple (Quo = 1, M = 1, Rem = 0) yields Q = 1 with normal 9-cycle latency.
- Back-to-back triples with out_ready tied high → results spaced exactly 11 cycles apart; each Q matches Quo × M + Rem.
